// File: rtl/riscv_defines.sv
// Shared load-unit definitions: LoadOp encodings, FSM states and size/alignment helpers.
// MISALIGNED_LOAD_EN adds the RD1 state used for word-crossing loads.
package riscv_defines;

  typedef enum logic [2:0] {
    LOAD_OP_LB  = 3'b000,
    LOAD_OP_LH  = 3'b001,
    LOAD_OP_LW  = 3'b010,
    LOAD_OP_LBU = 3'b100,
    LOAD_OP_LHU = 3'b101
  } LoadOp_t;

`ifdef MISALIGNED_LOAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2, RESP = 2'd3} lsu_state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RD0 = 2'd1, RESP = 2'd3} lsu_state_e;
`endif

  // Access size in bytes; 0 marks an illegal operation.
  function automatic logic [2:0] load_size(LoadOp_t op);
    case (op)
      LOAD_OP_LB, LOAD_OP_LBU: return 3'd1;
      LOAD_OP_LH, LOAD_OP_LHU: return 3'd2;
      LOAD_OP_LW:              return 3'd4;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic logic load_crosses_word(LoadOp_t op, logic [1:0] off);
    return ({1'b0, off} + load_size(op)) > 3'd4;
  endfunction

  function automatic logic load_misaligned(LoadOp_t op, logic [1:0] off);
    logic [1:0] mask;
    mask = 2'(load_size(op) - 3'd1);
    return (off & mask) != 2'b00;
  endfunction

endpackage

// File: rtl/load_alignment_unit_if.sv
// Request, memory and response signals of the load alignment unit.
interface load_alignment_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import riscv_defines::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  LoadOp_t           LoadOp;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_fault;

  modport master (
    output req_valid, req_addr, LoadOp, mem_ready, mem_rdata,
    input  req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, LoadOp, mem_ready, mem_rdata,
    output req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/load_alignment_unit_extract.sv
// Combinational byte/halfword/word extraction and sign/zero extension from a two-word window.
module load_extract
  import riscv_defines::*;
(
  input  logic [63:0] word_i,
  input  logic [1:0]  offset_i,
  input  LoadOp_t     op_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  assign sh = 32'(word_i >> {offset_i, 3'b000});

  always_comb begin
    data_o = '0;
    case (op_i)
      LOAD_OP_LB:  data_o = {{24{sh[7]}}, sh[7:0]};
      LOAD_OP_LBU: data_o = {24'h0, sh[7:0]};
      LOAD_OP_LH:  data_o = {{16{sh[15]}}, sh[15:0]};
      LOAD_OP_LHU: data_o = {16'h0, sh[15:0]};
      LOAD_OP_LW:  data_o = sh;
      default:     data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_alignment_unit.sv
// Load alignment unit: one or two word reads, then an aligned/extended single-cycle response.
// MISALIGNED_LOAD_EN services word-crossing loads through RD1; otherwise they fault.
module load_alignment_unit
  import riscv_defines::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  load_alignment_unit_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        off_q, off_d;
  LoadOp_t           op_q, op_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [63:0]       ext_word;
  logic [31:0]       ext_data;
  logic              req_fault;
`ifdef MISALIGNED_LOAD_EN
  logic [31:0]       lo_q, lo_d;
`endif

  always_comb begin
    req_fault = (load_size(bus.LoadOp) == 3'd0);
`ifndef MISALIGNED_LOAD_EN
    // Without the split path only naturally aligned accesses are serviced.
    req_fault = req_fault || load_misaligned(bus.LoadOp, bus.req_addr[1:0]);
`endif
  end

  always_comb begin
`ifdef MISALIGNED_LOAD_EN
    ext_word = (state_q == RD1) ? {bus.mem_rdata, lo_q} : {32'h0, bus.mem_rdata};
`else
    ext_word = {32'h0, bus.mem_rdata};
`endif
  end

  load_extract u_extract (
    .word_i   (ext_word),
    .offset_i (off_q),
    .op_i     (op_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    off_d       = off_q;
    op_d        = op_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
`ifdef MISALIGNED_LOAD_EN
    lo_d        = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          off_d      = bus.req_addr[1:0];
          op_d       = bus.LoadOp;
          if (req_fault) begin
            state_d     = RESP;
            rsp_data_d  = '0;
            rsp_fault_d = 1'b1;
          end else begin
            state_d = RD0;
          end
        end
      end
      RD0: begin
        if (bus.mem_ready) begin
`ifdef MISALIGNED_LOAD_EN
          lo_d = bus.mem_rdata;
          if (load_crosses_word(op_q, off_q)) begin
            state_d    = RD1;
            mem_addr_d = mem_addr_q + ADDR_W'(4);
          end else begin
            state_d     = RESP;
            rsp_data_d  = ext_data;
            rsp_fault_d = 1'b0;
          end
`else
          state_d     = RESP;
          rsp_data_d  = ext_data;
          rsp_fault_d = 1'b0;
`endif
        end
      end
`ifdef MISALIGNED_LOAD_EN
      RD1: begin
        if (bus.mem_ready) begin
          state_d     = RESP;
          rsp_data_d  = ext_data;
          rsp_fault_d = 1'b0;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      off_q       <= '0;
      op_q        <= LOAD_OP_LB;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      off_q       <= off_d;
      op_q        <= op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
`ifdef MISALIGNED_LOAD_EN
      lo_q        <= lo_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
`ifdef MISALIGNED_LOAD_EN
  assign bus.mem_valid = (state_q == RD0) || (state_q == RD1);
`else
  assign bus.mem_valid = (state_q == RD0);
`endif
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_alignment_unit.sv
// Bench for load_alignment_unit: directed vector table, reset/back-to-back sequences and
// randomized loads against a byte-addressed memory model. Honours MISALIGNED_LOAD_EN.
module tb_load_alignment_unit;
  import riscv_defines::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_alignment_unit_if #(.ADDR_W(32)) bus ();
  load_alignment_unit #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Memory contents: either two table words or a hash of the word address.
  bit          tbl_mode = 1'b0;
  logic [31:0] tbl_a0, tbl_w0, tbl_w1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (tbl_mode) return (a == tbl_a0) ? tbl_w0 : tbl_w1;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] b);
    logic [31:0] w;
    w = mem_word({b[31:2], 2'b00});
    return w[{b[1:0], 3'b000} +: 8];
  endfunction

  // Reference: gather bytes little-endian, extend, and apply the fault rules.
  task automatic model(input logic [31:0] addr, input logic [2:0] op,
                       output logic [31:0] data, output bit fault, output int nreads);
    int size;
    logic [63:0] v;
    v = '0;
    case (op)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    fault = (size == 0);
`ifndef MISALIGNED_LOAD_EN
    if (size != 0 && (addr % 32'(size)) != 0) fault = 1'b1;
`endif
    data   = '0;
    nreads = 0;
    if (!fault) begin
      for (int i = 0; i < size; i++) v = v | (64'(mem_byte(addr + 32'(i))) << (8 * i));
      data = v[31:0];
      if (size < 4 && op < 3'd4 && v[8*size-1]) data = data | ~((32'd1 << (8 * size)) - 32'd1);
      nreads = (int'(addr[1:0]) + size > 4) ? 2 : 1;
    end
  endtask

  // Memory responder with a per-read wait of cur_delay cycles.
  int          delay_mode = 0;
  int          cur_delay = 0;
  int          hold_cnt = 0;
  int          valid_cycles = 0;
  bit          misalign_seen = 1'b0;
  logic [31:0] reads[$];

  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    if (bus.mem_valid) begin
      valid_cycles++;
      if (bus.mem_addr[1:0] != 2'b00) misalign_seen = 1'b1;
      if (hold_cnt >= cur_delay) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        reads.push_back(bus.mem_addr);
        hold_cnt  = 0;
        cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 2)) : delay_mode;
      end else begin
        hold_cnt++;
      end
    end else begin
      hold_cnt = 0;
    end
  end

  task automatic run_load(input string nm, input logic [31:0] addr, input logic [2:0] op,
                          input int dly, input logic [31:0] exp_data, input bit exp_fault,
                          input int exp_reads, input int exp_cycles);
    int cyc;
    bit seen;
    logic [31:0] a0;
    a0  = {addr[31:2], 2'b00};
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
    delay_mode    = dly;
    cur_delay     = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
    valid_cycles  = 0;
    misalign_seen = 1'b0;
    reads.delete();
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.LoadOp    = LoadOp_t'(op);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 40) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, " rsp_valid seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, " rsp_data"}, bus.rsp_data, exp_data);
      chk({nm, " rsp_fault"}, 32'(bus.rsp_fault), 32'(exp_fault));
      if (exp_cycles >= 0) chk({nm, " latency"}, 32'(cyc), 32'(exp_cycles));
      @(negedge clk);
      chk({nm, " rsp_valid pulse"}, 32'(bus.rsp_valid), 32'd0);
      chk({nm, " rsp_data held"}, bus.rsp_data, exp_data);
    end
    chk({nm, " read count"}, 32'(reads.size()), 32'(exp_reads));
    for (int i = 0; i < reads.size() && i < 2; i++)
      chk({nm, " mem_addr"}, reads[i], a0 + 32'(4 * i));
    if (dly >= 0) chk({nm, " mem_valid cycles"}, 32'(valid_cycles), 32'(exp_reads * (dly + 1)));
    chk({nm, " mem_addr aligned"}, 32'(misalign_seen), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  op;
    logic [31:0] w0;
    logic [31:0] w1;
    int          dly;
    logic [31:0] data;
    bit          fault;
    int          nreads;
    int          cycles;
  } vec_t;

  vec_t vt[12];

  initial begin : main
    logic [31:0] edata;
    bit          efault;
    int          enr;
    logic [2:0]  ops[10];
    int          acc_at[$];
    int          rsp_at[$];
    logic [31:0] rsp_dat[$];
    int          w, cnt_v;

    vt[0]  = '{32'h0000_1003, LOAD_OP_LB,  32'h80FF_0000, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 1, 2};
    vt[1]  = '{32'h0000_2002, LOAD_OP_LHU, 32'hBEEF_1234, 32'h0, 3, 32'h0000_BEEF, 1'b0, 1, 5};
    vt[3]  = '{32'h0000_1002, LOAD_OP_LH,  32'h8001_0000, 32'h0, 0, 32'hFFFF_8001, 1'b0, 1, 2};
    vt[4]  = '{32'h0000_1001, LOAD_OP_LBU, 32'h0000_F000, 32'h0, 1, 32'h0000_00F0, 1'b0, 1, 3};
    vt[5]  = '{32'h0000_1000, LOAD_OP_LW,  32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1, 2};
    vt[6]  = '{32'h0000_1000, 3'd3,        32'h1234_5678, 32'h0, 0, 32'h0,         1'b1, 0, 1};
    vt[7]  = '{32'h0000_1003, 3'd7,        32'h1234_5678, 32'h0, 0, 32'h0,         1'b1, 0, 1};
    vt[11] = '{32'h0000_1FFE, LOAD_OP_LH,  32'h7FFF_0000, 32'h0, 0, 32'h0000_7FFF, 1'b0, 1, 2};
`ifdef MISALIGNED_LOAD_EN
    vt[2]  = '{32'h0000_3001, LOAD_OP_LW,  32'h4433_2211, 32'h8877_6655, 0, 32'h5544_3322, 1'b0, 2, 3};
    vt[8]  = '{32'h0000_1001, LOAD_OP_LH,  32'h00AB_CD00, 32'h0, 0, 32'hFFFF_ABCD, 1'b0, 1, 2};
    vt[9]  = '{32'h0000_1FFF, LOAD_OP_LHU, 32'h7F00_0000, 32'h0000_00FF, 0, 32'h0000_FF7F, 1'b0, 2, 3};
    vt[10] = '{32'hFFFF_FFFE, LOAD_OP_LW,  32'hAABB_0000, 32'h0000_DDCC, 0, 32'hDDCC_AABB, 1'b0, 2, 3};
`else
    vt[2]  = '{32'h0000_3001, LOAD_OP_LW,  32'h4433_2211, 32'h8877_6655, 0, 32'h0, 1'b1, 0, 1};
    vt[8]  = '{32'h0000_1001, LOAD_OP_LH,  32'h00AB_CD00, 32'h0, 0, 32'h0, 1'b1, 0, 1};
    vt[9]  = '{32'h0000_1FFF, LOAD_OP_LHU, 32'h7F00_0000, 32'h0000_00FF, 0, 32'h0, 1'b1, 0, 1};
    vt[10] = '{32'hFFFF_FFFE, LOAD_OP_LW,  32'hAABB_0000, 32'h0000_DDCC, 0, 32'h0, 1'b1, 0, 1};
`endif
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.LoadOp    = LOAD_OP_LB;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
    chk("reset rsp_data", bus.rsp_data, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    tbl_mode = 1'b1;
    foreach (vt[i]) begin
      tbl_a0 = {vt[i].addr[31:2], 2'b00};
      tbl_w0 = vt[i].w0;
      tbl_w1 = vt[i].w1;
      run_load($sformatf("vec%0d", i), vt[i].addr, vt[i].op, vt[i].dly,
               vt[i].data, vt[i].fault, vt[i].nreads, vt[i].cycles);
    end

    // Reset asserted while a read is outstanding
    delay_mode = 20;
    cur_delay  = 20;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1000;
    bus.LoadOp    = LOAD_OP_LW;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("midrst mem_valid before", 32'(bus.mem_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst mem_valid dropped", 32'(bus.mem_valid), 32'd0);
    chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst req_ready after", 32'(bus.req_ready), 32'd1);
    cnt_v = 0;
    repeat (6) begin
      if (bus.rsp_valid || bus.mem_valid) cnt_v++;
      @(negedge clk);
    end
    chk("midrst no activity", 32'(cnt_v), 32'd0);

    // Back-to-back requests with req_valid held
    tbl_a0     = 32'h0000_4000;
    tbl_w0     = 32'h1122_3344;
    tbl_w1     = 32'h0;
    delay_mode = 0;
    cur_delay  = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_4000;
    bus.LoadOp    = LOAD_OP_LW;
    for (int i = 0; i < 12; i++) begin
      if (acc_at.size() == 1) begin
        bus.req_addr = 32'h0000_4002;
        bus.LoadOp   = LOAD_OP_LBU;
      end else if (acc_at.size() >= 2) begin
        bus.req_valid = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) acc_at.push_back(i);
      if (bus.rsp_valid) begin
        rsp_at.push_back(i);
        rsp_dat.push_back(bus.rsp_data);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b accepts", 32'(acc_at.size()), 32'd2);
    chk("b2b responses", 32'(rsp_at.size()), 32'd2);
    if (acc_at.size() == 2 && rsp_at.size() >= 1)
      chk("b2b second accept after rsp", 32'(acc_at[1] - rsp_at[0]), 32'd1);
    if (rsp_dat.size() == 2) begin
      chk("b2b data0", rsp_dat[0], 32'h1122_3344);
      chk("b2b data1", rsp_dat[1], 32'h0000_0022);
    end

    // Randomized loads against the reference model
    tbl_mode = 1'b0;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [2:0]  op;
      int          dly;
      a = $urandom;
      if (i % 16 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      op  = ops[$urandom_range(0, 9)];
      dly = (i % 2 == 1) ? 0 : -1;
      model(a, op, edata, efault, enr);
      run_load($sformatf("rnd%0d", i), a, op, dly, edata, efault, enr,
               (dly == 0) ? (efault ? 1 : enr + 1) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_alignment_unit.md
LOAD_ALIGNMENT_UNIT -- requirements
Module: load_alignment_unit

Interface
- REQ-001 Parameter ADDR_W, default 32: width of the byte address; SHALL be at least 3.
- REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
- REQ-003 rst  input  1  reset, asynchronous and active-high.
- REQ-004 req_valid  input  1  the core presents a load request.
- REQ-005 req_ready  output  1  the unit accepts a request; SHALL be high only in IDLE.
- REQ-006 req_addr  input  ADDR_W  byte address of the load.
- REQ-007 LoadOp  input  LoadOp_t (3 bits)  one of LOAD_OP_LB, LOAD_OP_LBU, LOAD_OP_LH, LOAD_OP_LHU or LOAD_OP_LW.
- REQ-008 mem_valid  output  1  a word read request to memory.
- REQ-009 mem_ready  input  1  memory returns mem_rdata in this cycle.
- REQ-010 mem_addr  output  ADDR_W  word-aligned read address; bits [1:0] SHALL always be 0.
- REQ-011 mem_rdata  input  32  read word, valid only when mem_valid and mem_ready are both high.
- REQ-012 rsp_valid  output  1  single-cycle pulse marking the load result.
- REQ-013 rsp_data  output  32  aligned and extended load result.
- REQ-014 rsp_fault  output  1  the load was misaligned and not serviced, or LoadOp was illegal.

Function
- REQ-015 The FSM SHALL have the states IDLE, RD0, RD1 and RESP.
- REQ-016 Handshake: request accepted when req_valid and req_ready are both high.
  - Address, LoadOp and offset latched.
  - Next state SHALL be RD0.
  - A request that must fault SHALL go directly to RESP.
- REQ-017 In RD0 the unit SHALL drive mem_valid=1 and mem_addr={addr[ADDR_W-1:2],2'b00}, both held stable until mem_ready.
- REQ-018 When mem_ready arrives in RD0, the word SHALL be captured as lo.
  - Next state is RD1 for a word-crossing access (REQ-026).
  - Otherwise next state is RESP.
- REQ-019 In RD1 the unit SHALL drive mem_addr = first word address + 4, wrapping modulo 2^ADDR_W.
  - On mem_ready it SHALL capture hi and go to RESP.
- REQ-020 In RESP the unit SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
  - rsp_data and rsp_fault SHALL be held until the next response.
- REQ-021 Extraction from sh = ({hi,lo} >> 8*offset), where hi is 0 for a single-word access:
  - LB: sign-extend sh[7:0].
  - LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0].
  - LHU: zero-extend sh[15:0].
  - LW: sh[31:0].
- REQ-022 Latency with zero-wait memory (mem_ready=1 constantly):
  - Request accepted at edge 0.
  - mem_valid in cycle 1.
  - rsp_valid in cycle 2.
  - A split access adds one cycle.
- REQ-023 A fault response SHALL carry rsp_data=0 and rsp_fault=1, and SHALL issue no memory request.
- REQ-024 An illegal LoadOp SHALL fault regardless of the address.
- REQ-025 A new request SHALL NOT be accepted during RD0, RD1 or RESP; req_ready=0 in those states.

Reset
- REQ-026 Word-crossing access: LH/LHU with offset 3, or LW with offset other than 0.
- REQ-027 While rst is high the unit SHALL hold:
  - state IDLE
  - mem_valid=0, rsp_valid=0, rsp_fault=0
  - rsp_data=0, mem_addr=0
- REQ-028 A reset asserted mid-transaction SHALL drop mem_valid immediately and SHALL produce no response.
  - Operation SHALL resume in IDLE at the first edge after release.

Configuration
- REQ-029 MISALIGNED_LOAD_EN defined: a word-crossing access SHALL be serviced as two word reads through RD1.
- REQ-030 MISALIGNED_LOAD_EN undefined:
  - RD1 SHALL NOT exist.
  - Every word-crossing access SHALL fault per REQ-023.
  - A halfword at offset 1 SHALL also fault.

Structure
- REQ-031 The following SHALL live in the shared riscv_defines package/header:
  - LoadOp_t and its LOAD_OP_* encodings.
  - The FSM state enumeration.
- REQ-032 The extraction and extension logic SHALL be one combinational sub-module, load_extract.
  - Inputs: {hi,lo}, offset, LoadOp.
  - Output: rsp_data.

Verification
- REQ-033 LB at 0x1003, mem_rdata=0x80FF_0000, zero-wait memory -> rsp_valid in cycle 2, rsp_data=0xFFFF_FF80, rsp_fault=0.
- REQ-034 LHU at 0x2002, mem_rdata=0xBEEF_1234, mem_ready delayed 3 cycles -> mem_addr=0x2000 held for 4 cycles, then rsp_data=0x0000_BEEF.
- REQ-035 LW at 0x3001 with MISALIGNED_LOAD_EN, words 0x4433_2211 and 0x8877_6655:
  - mem_addr=0x3000 then 0x3004.
  - rsp_data=0x5544_3322.
- REQ-036 Same LW as REQ-035 without MISALIGNED_LOAD_EN -> no mem_valid, rsp_valid in cycle 1, rsp_fault=1, rsp_data=0.
- REQ-037 rst pulsed while in RD0 with mem_valid=1 -> mem_valid=0 in the same cycle, no rsp_valid, req_ready=1 after release.
- REQ-038 Back-to-back requests with req_valid held high -> the second request is accepted only in the cycle after the first rsp_valid.
